prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader: writer side of the CPU's instruction-fetch path. Receives
//  a framed byte stream, packs it into 16-bit instruction words and writes them into
//  MemoryUnit at byte addresses BASE_ADDR, +2, +4, ... (matching the PC's +2 step).
//  Holds the CPU in reset (cpu_rst_b low) until a load completes with a good checksum.
// PARAMETERS
//  DATA_W     16       memory word width; fixed at 16, the parameter is for documentation
//  ADDR_W     16       memory byte-address width
//  BASE_ADDR  16'h0000 byte address of the first program word
//  MAX_WORDS  16'd4096 largest accepted word count; larger headers go to ERROR
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_b      in   1       synchronous, active-low reset
//  start      in   1       1-cycle pulse; arms a load from IDLE, DONE or ERROR
//  in_data    in   8       stream byte
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       loader accepts a byte this cycle (transfer = valid & ready)
//  mem_e      out  1       memory enable, to MemoryUnit e
//  mem_we     out  1       memory write enable, to MemoryUnit we
//  mem_addr   out  ADDR_W  memory byte address
//  mem_wdata  out  DATA_W  write word
//  cpu_rst_b  out  1       active-low reset to CPU; high only in DONE
//  busy       out  1       high in LEN, DATA, WRITE and CSUM
//  done       out  1       high in DONE
//  error      out  1       high in ERROR
//  word_cnt   out  16      words written so far in the current load
// BEHAVIOUR
//  - Reset (rst_b=0 at a clk edge): state IDLE. All outputs 0, including cpu_rst_b,
//    in_ready, mem_e, mem_we, mem_addr, mem_wdata and word_cnt.
//  - Frame: LEN word (2 bytes), then LEN data words (2 bytes each), then CSUM word.
//    Every word is big-endian: the first byte becomes [15:8] and the second becomes [7:0].
//  - CSUM is the XOR of all data words. The CSUM for LEN=0 is 16'h0000.
//  - FSM transitions:
//    IDLE  -start-> LEN
//    LEN   -word complete-> ERROR if LEN>MAX_WORDS, CSUM if LEN==0, otherwise DATA
//    DATA  -word complete-> WRITE
//    WRITE -1 cycle-> DATA if word_cnt<LEN after the increment, otherwise CSUM
//    CSUM  -word complete-> DONE if it matches the running XOR, otherwise ERROR
//    DONE  -start-> LEN
//    ERROR -start-> LEN
//  - in_ready = 1 in LEN, DATA and CSUM; 0 in WRITE, IDLE, DONE and ERROR.
//    Bytes offered while in_ready=0 are not consumed.
//  - WRITE (exactly 1 cycle):
//    - mem_e=1, mem_we=1, mem_addr=BASE_ADDR+2*word_cnt (mod 2^ADDR_W), mem_wdata=word.
//    - word_cnt increments at the end of the cycle; the running XOR is updated.
//    - mem_e, mem_we are 0 in every other state.
//  - Latency: the WRITE cycle starts on the clk edge after the second byte of a word is
//    accepted. Sustained throughput is 2 bytes per 3 cycles.
//  - start received in LEN, DATA, WRITE or CSUM is ignored. A load cannot be aborted
//    except by rst_b.
//  - Re-arm: on entry to LEN, word_cnt, the running XOR and the byte phase clear to 0.
//    cpu_rst_b drops to 0 on the same edge.
//  - Reset mid-load: returns to IDLE on that edge. A partially written program remains
//    in memory but cpu_rst_b stays 0.
//  - Address wrap: must not occur for legal parameters (BASE_ADDR+2*MAX_WORDS <= 2^ADDR_W).
//    Otherwise the address wraps modulo 2^ADDR_W; no error is flagged.
//  - in_valid with no ready, or a gap between the two bytes of a word, only stalls the FSM.
// STRUCTURE
//  - Shared package cpu_pkg: loader_state_t enum (IDLE, LEN, DATA, WRITE, CSUM, DONE,
//    ERROR) and the constant WORD_BYTES=2.
//  - Sub-module byte_pair_assembler (clk, rst_b, clr, byte_in, byte_valid -> word_out,
//    word_valid):
//    - 1-bit phase and a high-byte register.
//    - word_valid pulses for 1 cycle when the second byte of a word is accepted.
//  - The top level holds the FSM, word_cnt, LEN register, XOR accumulator and address
//    adder, all registered.
// TESTING
//  1. Reset, start, stream 00 02 | 12 34 | AB CD | B9 F9
//     -> writes 16'h1234@0x0000 and 16'hABCD@0x0002; done=1; cpu_rst_b=1; word_cnt=2.
//  2. Same as 1 with CSUM byte B9 F8
//     -> error=1, cpu_rst_b=0; both writes still occurred.
//  3. LEN=00 00, CSUM=00 00
//     -> no mem_we pulses; done=1.
//  4. LEN=16'h1001 with MAX_WORDS=4096
//     -> error=1 after the 2nd byte; in_ready=0 afterwards; no memory writes.
//  5. in_valid held high continuously
//     -> in_ready=0 exactly in each WRITE cycle; no byte lost or duplicated
//        (verified by a scoreboard against the memory model).
//  6. rst_b=0 for one cycle after the 3rd data word is written
//     -> IDLE, all outputs 0.
//     -> A subsequent start plus a valid frame completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader types and constants
// Purpose: loader FSM state encoding and the byte width of one program word.
// Ports: none (package).
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

  // Bytes per instruction word; also the PC / address step.
  localparam int unsigned WORD_BYTES = 2;

endpackage

// File: rtl/byte_pair_assembler.sv
// rtl/byte_pair_assembler.sv - packs two stream bytes into one big-endian word
// Purpose: first accepted byte is held as [15:8]; the second completes the word.
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   synchronous active-low reset
//   clr        in   restart at the high byte (dominates byte_valid)
//   byte_in    in   8-bit byte, meaningful when byte_valid
//   byte_valid in   a byte is being transferred this cycle
//   word_out   out  {high byte, byte_in}, meaningful when word_valid
//   word_valid out  1-cycle pulse in the cycle the second byte is transferred
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] word_out,
  output logic        word_valid
);

  logic       phase_q;
  logic       phase_d;
  logic [7:0] hi_q;
  logic [7:0] hi_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (clr) begin
      phase_d = 1'b0;
    end else if (byte_valid) begin
      if (!phase_q) begin
        hi_d = byte_in;
      end
      phase_d = ~phase_q;
    end
  end

  // The word is presented combinationally so the owner can register it on the
  // same edge that accepts the low byte.
  assign word_valid = byte_valid & phase_q & ~clr;
  assign word_out   = {hi_q, byte_in};

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader into instruction memory
// Purpose: receives LEN | LEN data words | CSUM (all big-endian 16-bit), writes
//   each data word at BASE_ADDR + 2*index, and releases the CPU reset only after
//   a load whose checksum (XOR of data words) matches.
// Ports:
//   clk, rst_b            clock, synchronous active-low reset
//   start                 1-cycle pulse arming a load from IDLE/DONE/ERROR
//   in_data/valid/ready   byte stream, transfer when valid & ready
//   mem_e/we/addr/wdata   write port to MemoryUnit, active only in WRITE
//   cpu_rst_b             active-low CPU reset, high only in DONE
//   busy/done/error       status flags
//   word_cnt              words written so far in the current load
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0]       MAX_WORDS = 16'd4096
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_e,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_b,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_cnt
);

  loader_state_t     state_q;
  loader_state_t     state_d;
  logic [15:0]       word_cnt_q;
  logic [15:0]       len_q;
  logic [15:0]       xor_q;
  logic              mem_e_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic        arm;
  logic        xfer;
  logic [15:0] word;
  logic        word_valid;

  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign xfer     = in_valid & in_ready;
  assign arm      = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst_b      (rst_b),
    .clr        (arm),
    .byte_in    (in_data),
    .byte_valid (xfer),
    .word_out   (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (word_valid) begin
          if (word > MAX_WORDS)  state_d = ERROR;
          else if (word == 16'd0) state_d = CSUM;
          else                   state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        // Compare against the count as it will be after this write.
        if ((word_cnt_q + 16'd1) < len_q) state_d = DATA;
        else                              state_d = CSUM;
      end
      CSUM: begin
        if (word_valid) state_d = (word == xor_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      word_cnt_q  <= 16'd0;
      len_q       <= 16'd0;
      xor_q       <= 16'd0;
      mem_e_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Write strobes are registered so they are high exactly for the WRITE cycle.
      mem_e_q <= (state_d == WRITE);
      if (arm) begin
        word_cnt_q <= 16'd0;
        xor_q      <= 16'd0;
      end
      if ((state_q == LEN) && word_valid) begin
        len_q <= word;
      end
      if ((state_q == DATA) && word_valid) begin
        mem_wdata_q <= word;
        mem_addr_q  <= BASE_ADDR + ADDR_W'(word_cnt_q * WORD_BYTES);
      end
      if (state_q == WRITE) begin
        word_cnt_q <= word_cnt_q + 16'd1;
        xor_q      <= xor_q ^ mem_wdata_q;
      end
    end
  end

  assign mem_e     = mem_e_q;
  assign mem_we    = mem_e_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_cnt  = word_cnt_q;
  assign cpu_rst_b = (state_q == DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);
  assign busy      = (state_q == LEN) || (state_q == DATA) ||
                     (state_q == WRITE) || (state_q == CSUM);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_e;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst_b;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  bit          chk_ready = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_e     (mem_e),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_b (cpu_rst_b),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write is matched against the expected-write queue.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %h@%h expected no write", mem_wdata, mem_addr);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {mem_addr, mem_wdata}, exp_w);
        check("write_mem_e", {31'd0, mem_e}, 32'd1);
        check("ready_in_write", {31'd0, in_ready}, 32'd0);
      end
    end else if (chk_ready && busy === 1'b1) begin
      check("ready_outside_write", {31'd0, in_ready}, 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("armed_busy", {31'd0, busy}, 32'd1);
    check("armed_cpu_rst_b", {31'd0, cpu_rst_b}, 32'd0);
  endtask

  task automatic end_frame();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {25'd0, cpu_rst_b, in_ready, mem_e, mem_we, busy, done, error}, 32'd0);
    check({name, "_bus"}, {mem_addr, mem_wdata}, 32'd0);
    check({name, "_cnt"}, {16'd0, word_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_b    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_b = 1'b1;

    // 1: good two-word load with stalls between bytes
    do_start();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    send_word(16'h0002, 1'b1);
    send_word(16'h1234, 1'b1);
    send_word(16'hABCD, 1'b0);
    send_word(16'hB9F9, 1'b0);
    check("t1_done", {29'd0, done, cpu_rst_b, error}, 32'b110);
    check("t1_cnt", {16'd0, word_cnt}, 32'd2);
    end_frame();

    // 2: bad checksum, writes still happen
    do_start();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    send_word(16'h0002, 1'b0);
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    send_word(16'hB9F8, 1'b0);
    check("t2_error", {29'd0, done, cpu_rst_b, error}, 32'b001);
    check("t2_cnt", {16'd0, word_cnt}, 32'd2);
    end_frame();

    // 3: empty program
    do_start();
    send_word(16'h0000, 1'b0);
    send_word(16'h0000, 1'b0);
    check("t3_done", {29'd0, done, cpu_rst_b, error}, 32'b110);
    check("t3_cnt", {16'd0, word_cnt}, 32'd0);
    end_frame();

    // 4: oversize LEN
    do_start();
    send_word(16'h1001, 1'b0);
    check("t4_error", {29'd0, done, cpu_rst_b, error}, 32'b001);
    check("t4_ready", {31'd0, in_ready}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_ready_held", {31'd0, in_ready}, 32'd0);
    check("t4_still_error", {29'd0, done, cpu_rst_b, error}, 32'b001);
    end_frame();

    // 5: in_valid held high for the whole frame
    do_start();
    chk_ready = 1'b1;
    exp_q.push_back({16'h0000, 16'h0102});
    exp_q.push_back({16'h0002, 16'h0304});
    exp_q.push_back({16'h0004, 16'h0506});
    exp_q.push_back({16'h0006, 16'h0708});
    exp_q.push_back({16'h0008, 16'h090A});
    send_word(16'h0005, 1'b0);
    send_word(16'h0102, 1'b0);
    send_word(16'h0304, 1'b0);
    send_word(16'h0506, 1'b0);
    send_word(16'h0708, 1'b0);
    send_word(16'h090A, 1'b0);
    send_word(16'h0902, 1'b0);
    chk_ready = 1'b0;
    check("t5_done", {29'd0, done, cpu_rst_b, error}, 32'b110);
    check("t5_cnt", {16'd0, word_cnt}, 32'd5);
    end_frame();

    // 6: reset after the third write, then a clean reload
    do_start();
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0002, 16'h2222});
    exp_q.push_back({16'h0004, 16'h3333});
    send_word(16'h0004, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (word_cnt !== 16'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_third_write", {16'd0, word_cnt}, 32'd3);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t6_reset");
    check("t6_queue", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    do_start();
    exp_q.push_back({16'h0000, 16'h0001});
    exp_q.push_back({16'h0002, 16'h0002});
    exp_q.push_back({16'h0004, 16'h0004});
    send_word(16'h0003, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    send_word(16'h0004, 1'b0);
    send_word(16'h0007, 1'b0);
    check("t6_done", {29'd0, done, cpu_rst_b, error}, 32'b110);
    check("t6_cnt", {16'd0, word_cnt}, 32'd3);
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
